// File: rtl/ex_result_stage_pkg.sv
// ============================================================================
//  Module   : ex_result_stage_pkg
//  Brief    : Shared EX/MEM record layout, kind/size codes and store-lane helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ex_result_stage_pkg;

    localparam int EX_XLEN = 32;

    localparam logic [2:0] EX_KIND_ALU    = 3'd0;
    localparam logic [2:0] EX_KIND_LOAD   = 3'd1;
    localparam logic [2:0] EX_KIND_STORE  = 3'd2;
    localparam logic [2:0] EX_KIND_BRANCH = 3'd3;
    localparam logic [2:0] EX_KIND_JAL    = 3'd4;
    localparam logic [2:0] EX_KIND_JALR   = 3'd5;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [EX_XLEN-1:0] pc;
        logic [4:0]         rd;
        logic               wen;
        logic [2:0]         kind;
        logic [1:0]         size;
        logic [EX_XLEN-1:0] result;
        logic [EX_XLEN-1:0] addr;
        logic [EX_XLEN-1:0] wdata;
        logic               misaligned;
    } ex_rec_t;

    localparam int EX_REC_W = $bits(ex_rec_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    function automatic logic [EX_XLEN-1:0] replicate_store(
        input logic [1:0]         size,
        input logic [EX_XLEN-1:0] data
    );
        logic [EX_XLEN-1:0] lanes;
        case (size)
            MEM_SIZE_BYTE: lanes = {4{data[7:0]}};
            MEM_SIZE_HALF: lanes = {2{data[15:0]}};
            default:       lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_skid_buf.sv
// ============================================================================
//  Module   : ex_skid_buf
//  Brief    : Generic 2-entry valid/ready skid buffer; ready is registered.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ex_skid_buf #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    import ex_result_stage_pkg::*;

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_push;
    logic             w_pop;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // Ready comes straight from the state register, so no path from i_ready.
    assign o_ready = (r_state != SKID_TWO);
    assign o_valid = (r_state != SKID_EMPTY);
    assign o_data  = r_main;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = SKID_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_push && w_pop) begin
                    w_load_main_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = SKID_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (w_pop) begin
                    w_state_nxt      = SKID_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt      = SKID_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            if (w_load_main_in) begin
                r_main <= i_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_result_stage.sv
// ============================================================================
//  Module   : ex_result_stage
//  Brief    : EX->MEM boundary register: results, redirect, memory address/data.
//             Define EX_SKID_EN for the 2-entry skid buffer with registered ready.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ex_result_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            io_flush,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [XLEN-1:0] io_in_pc,
    input  logic [2:0]      io_in_kind,
    input  logic [XLEN-1:0] io_in_imm,
    input  logic [4:0]      io_in_rd,
    input  logic            io_in_wen,
    input  logic [1:0]      io_in_size,
    input  logic [XLEN-1:0] io_in_store_data,
    input  logic [XLEN-1:0] io_alu_out,
    input  logic [XLEN-1:0] io_alu_adder_out,
    input  logic            io_alu_cmp_out,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_pc,
    output logic [4:0]      io_out_rd,
    output logic            io_out_wen,
    output logic [2:0]      io_out_kind,
    output logic [1:0]      io_out_size,
    output logic [XLEN-1:0] io_out_result,
    output logic [XLEN-1:0] io_out_addr,
    output logic [XLEN-1:0] io_out_wdata,
    output logic            io_out_misaligned,
    output logic            io_redirect_valid,
    output logic [XLEN-1:0] io_redirect_target
);
    import ex_result_stage_pkg::*;

    localparam ex_rec_t c_rec_reset = '{pc: RESET_PC, default: '0};

    logic            w_fire;
    logic            w_is_mem;
    logic            w_is_branch;
    logic            w_is_jump;
    logic            w_taken;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_mis_mem;
    logic            w_mis_jump;
    logic            w_misaligned;
    logic            w_redirect;
    ex_rec_t         w_rec;
    ex_rec_t         w_out_rec;
    logic            w_out_valid;
    logic            r_redir_valid;
    logic [XLEN-1:0] r_redir_target;

    assign w_fire      = io_in_valid && io_in_ready;
    assign w_is_mem    = (io_in_kind == EX_KIND_LOAD) || (io_in_kind == EX_KIND_STORE);
    assign w_is_branch = (io_in_kind == EX_KIND_BRANCH);
    assign w_is_jump   = (io_in_kind == EX_KIND_JAL) || (io_in_kind == EX_KIND_JALR);
    assign w_taken     = w_is_jump || (w_is_branch && io_alu_cmp_out);
    assign w_pc_plus4  = io_in_pc + 32'd4;

    // JALR drops bit 0 of the computed target; everything else is pc-relative.
    assign w_target = (io_in_kind == EX_KIND_JALR) ? {io_alu_adder_out[XLEN-1:1], 1'b0}
                                                   : io_in_pc + io_in_imm;

    assign w_mis_mem = w_is_mem &&
                       (((io_in_size == MEM_SIZE_HALF) && io_alu_adder_out[0]) ||
                        ((io_in_size == MEM_SIZE_WORD) && (io_alu_adder_out[1:0] != 2'b00)));
    assign w_mis_jump   = w_taken && w_target[1];
    assign w_misaligned = w_mis_mem || w_mis_jump;
    assign w_redirect   = w_taken && !w_misaligned;

    always_comb begin
        w_rec            = c_rec_reset;
        w_rec.pc         = io_in_pc;
        w_rec.rd         = io_in_rd;
        w_rec.wen        = io_in_wen && !w_is_branch && !w_misaligned;
        w_rec.kind       = io_in_kind;
        w_rec.size       = io_in_size;
        w_rec.addr       = w_is_mem ? io_alu_adder_out : '0;
        w_rec.wdata      = replicate_store(io_in_size, io_in_store_data);
        w_rec.misaligned = w_misaligned;
        if (w_is_branch) begin
            w_rec.result = '0;
        end else if (w_is_jump) begin
            w_rec.result = w_pc_plus4;
        end else begin
            w_rec.result = io_alu_out;
        end
    end

`ifdef EX_SKID_EN
    logic [EX_REC_W-1:0] w_skid_data;

    ex_skid_buf #(
        .WIDTH     (EX_REC_W),
        .RESET_VAL (c_rec_reset)
    ) u_skid (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_flush (io_flush),
        .i_valid (io_in_valid),
        .o_ready (io_in_ready),
        .i_data  (w_rec),
        .o_valid (w_out_valid),
        .i_ready (io_out_ready),
        .o_data  (w_skid_data)
    );

    assign w_out_rec = ex_rec_t'(w_skid_data);
`else
    logic    r_valid;
    ex_rec_t r_rec;

    assign io_in_ready = !r_valid || io_out_ready;
    assign w_out_valid = r_valid;
    assign w_out_rec   = r_rec;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_rec   <= c_rec_reset;
        end else if (io_flush) begin
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_rec   <= w_rec;
        end else if (io_out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

    // Redirect is tied to acceptance, not to the record reaching the memory stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_redir_valid  <= 1'b0;
            r_redir_target <= RESET_PC;
        end else begin
            r_redir_valid <= w_fire && !io_flush && w_redirect;
            if (w_fire && !io_flush && w_redirect) begin
                r_redir_target <= w_target;
            end
        end
    end

    assign io_out_valid       = w_out_valid;
    assign io_out_pc          = w_out_rec.pc;
    assign io_out_rd          = w_out_rec.rd;
    assign io_out_wen         = w_out_rec.wen;
    assign io_out_kind        = w_out_rec.kind;
    assign io_out_size        = w_out_rec.size;
    assign io_out_result      = w_out_rec.result;
    assign io_out_addr        = w_out_rec.addr;
    assign io_out_wdata       = w_out_rec.wdata;
    assign io_out_misaligned  = w_out_rec.misaligned;
    assign io_redirect_valid  = r_redir_valid;
    assign io_redirect_target = r_redir_target;

endmodule

`default_nettype wire

// File: tb/tb_ex_result_stage.sv
// ============================================================================
//  Module   : tb_ex_result_stage
//  Brief    : Scoreboard bench for ex_result_stage with a behavioural reference.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_result_stage;

    localparam logic [31:0] RPC = 32'h0000_0080;

    localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2,
                           K_BR  = 3'd3, K_JAL  = 3'd4, K_JALR  = 3'd5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        io_flush = 1'b0;
    logic        io_in_valid = 1'b0;
    logic        io_in_ready;
    logic [31:0] io_in_pc = '0;
    logic [2:0]  io_in_kind = '0;
    logic [31:0] io_in_imm = '0;
    logic [4:0]  io_in_rd = '0;
    logic        io_in_wen = 1'b0;
    logic [1:0]  io_in_size = '0;
    logic [31:0] io_in_store_data = '0;
    logic [31:0] io_alu_out = '0;
    logic [31:0] io_alu_adder_out = '0;
    logic        io_alu_cmp_out = 1'b0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b0;
    logic [31:0] io_out_pc;
    logic [4:0]  io_out_rd;
    logic        io_out_wen;
    logic [2:0]  io_out_kind;
    logic [1:0]  io_out_size;
    logic [31:0] io_out_result;
    logic [31:0] io_out_addr;
    logic [31:0] io_out_wdata;
    logic        io_out_misaligned;
    logic        io_redirect_valid;
    logic [31:0] io_redirect_target;

    ex_result_stage #(
        .XLEN     (32),
        .RESET_PC (RPC)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .io_flush           (io_flush),
        .io_in_valid        (io_in_valid),
        .io_in_ready        (io_in_ready),
        .io_in_pc           (io_in_pc),
        .io_in_kind         (io_in_kind),
        .io_in_imm          (io_in_imm),
        .io_in_rd           (io_in_rd),
        .io_in_wen          (io_in_wen),
        .io_in_size         (io_in_size),
        .io_in_store_data   (io_in_store_data),
        .io_alu_out         (io_alu_out),
        .io_alu_adder_out   (io_alu_adder_out),
        .io_alu_cmp_out     (io_alu_cmp_out),
        .io_out_valid       (io_out_valid),
        .io_out_ready       (io_out_ready),
        .io_out_pc          (io_out_pc),
        .io_out_rd          (io_out_rd),
        .io_out_wen         (io_out_wen),
        .io_out_kind        (io_out_kind),
        .io_out_size        (io_out_size),
        .io_out_result      (io_out_result),
        .io_out_addr        (io_out_addr),
        .io_out_wdata       (io_out_wdata),
        .io_out_misaligned  (io_out_misaligned),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_target (io_redirect_target)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [2:0]  kind;
        logic [1:0]  size;
        logic [31:0] result;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
        logic        redir;
        logic [31:0] target;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic        exp_redir = 1'b0;
    logic [31:0] exp_redir_tgt = '0;
    int          stall_left = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: architectural rules written as plain arithmetic on the inputs.
    function automatic exp_t model(input logic [2:0] kind, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic [31:0] alu,
                                   input logic [31:0] adder, input logic [31:0] sd,
                                   input logic [1:0] size, input logic cmp,
                                   input logic [4:0] rd, input logic wen);
        exp_t e;
        logic mem, taken;
        e.pc   = pc;
        e.rd   = rd;
        e.kind = kind;
        e.size = size;
        mem    = (kind == K_LOAD) || (kind == K_STORE);
        taken  = (kind == K_JAL) || (kind == K_JALR) || ((kind == K_BR) && cmp);
        e.target = (kind == K_JALR) ? adder - (adder % 32'd2) : pc + imm;
        if (kind == K_BR)                         e.result = 32'd0;
        else if (kind == K_JAL || kind == K_JALR) e.result = pc + 32'd4;
        else                                      e.result = alu;
        e.addr = mem ? adder : 32'd0;
        if (size == 2'd0)      e.wdata = (sd % 32'd256) * 32'h0101_0101;
        else if (size == 2'd1) e.wdata = (sd % 32'd65536) * 32'h0001_0001;
        else                   e.wdata = sd;
        e.mis = (mem && ((size == 2'd1 && (adder % 32'd2) != 0) ||
                         (size == 2'd2 && (adder % 32'd4) != 0))) ||
                (taken && (e.target % 32'd4) >= 32'd2);
        e.wen   = wen && (kind != K_BR) && !e.mis;
        e.redir = taken && !e.mis;
        return e;
    endfunction

    // Monitor / scoreboard: pops on handshake, pushes on accepted fire.
    always @(negedge clock) begin
        exp_t e;
        int   qsz;
        logic fire;
        if (!reset_n) begin
            q.delete();
            exp_redir = 1'b0;
        end else begin
            chk("redirect_valid", 32'(io_redirect_valid), 32'(exp_redir));
            if (exp_redir) chk("redirect_target", io_redirect_target, exp_redir_tgt);
            qsz = q.size();
            chk("out_valid", 32'(io_out_valid), 32'(qsz != 0));
`ifdef EX_SKID_EN
            chk("in_ready", 32'(io_in_ready), 32'(qsz < 2));
`else
            chk("in_ready", 32'(io_in_ready), 32'((qsz == 0) || io_out_ready));
`endif
            if (io_out_valid && io_out_ready && qsz != 0) begin
                e = q.pop_front();
                chk("out_pc", io_out_pc, e.pc);
                chk("out_rd", 32'(io_out_rd), 32'(e.rd));
                chk("out_wen", 32'(io_out_wen), 32'(e.wen));
                chk("out_kind", 32'(io_out_kind), 32'(e.kind));
                chk("out_size", 32'(io_out_size), 32'(e.size));
                chk("out_result", io_out_result, e.result);
                chk("out_addr", io_out_addr, e.addr);
                chk("out_wdata", io_out_wdata, e.wdata);
                chk("out_misaligned", 32'(io_out_misaligned), 32'(e.mis));
            end
            if (io_flush) q.delete();
            fire = io_in_valid && io_in_ready;
            e = model(io_in_kind, io_in_pc, io_in_imm, io_alu_out, io_alu_adder_out,
                      io_in_store_data, io_in_size, io_alu_cmp_out, io_in_rd, io_in_wen);
            exp_redir = fire && !io_flush && e.redir;
            if (exp_redir) exp_redir_tgt = e.target;
            if (fire && !io_flush) q.push_back(e);
        end
    end

    task automatic cyc(input logic v, input logic [2:0] k, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] alu, input logic [31:0] adder,
                       input logic [31:0] sd, input logic [1:0] sz, input logic cmp,
                       input logic fl, input logic ordy, output logic fired);
        io_in_valid      = v;
        io_in_kind       = k;
        io_in_pc         = pc;
        io_in_imm        = imm;
        io_alu_out       = alu;
        io_alu_adder_out = adder;
        io_in_store_data = sd;
        io_in_size       = sz;
        io_alu_cmp_out   = cmp;
        io_flush         = fl;
        io_out_ready     = ordy;
        io_in_rd         = 5'($urandom);
        io_in_wen        = 1'($urandom_range(0, 3) != 0);
        @(negedge clock);
        fired = v && io_in_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] k, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] adder, input logic [31:0] sd,
                        input logic [1:0] sz, input logic cmp);
        logic fired = 1'b0;
        for (int t = 0; t < 20 && !fired; t++) begin
            logic ordy;
            ordy = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            cyc(1'b1, k, pc, imm, alu, adder, sd, sz, cmp, 1'b0, ordy, fired);
        end
        if (!fired) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic f;
        for (int i = 0; i < n; i++) cyc(1'b0, K_ALU, 0, 0, 0, 0, 0, 2'd0, 1'b0, 1'b0, ordy, f);
    endtask

    initial begin
        logic f;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(io_out_valid), 32'd0);
        chk("rst_out_pc", io_out_pc, RPC);
        chk("rst_redirect_valid", 32'(io_redirect_valid), 32'd0);
        chk("rst_redirect_target", io_redirect_target, RPC);
        chk("rst_out_result", io_out_result, 32'd0);
        chk("rst_out_wdata", io_out_wdata, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        idle(1, 1'b1);

        send(K_BR, 32'h100, 32'h20, 32'h5, 32'h0, 32'h0, 2'd2, 1'b1);
        send(K_BR, 32'h100, 32'h20, 32'h5, 32'h0, 32'h0, 2'd2, 1'b0);
        send(K_JALR, 32'h400, 32'h0, 32'h0, 32'h2003, 32'h0, 2'd2, 1'b0);
        send(K_STORE, 32'h200, 32'h0, 32'h0, 32'h41, 32'h1234_5678, 2'd0, 1'b0);
        send(K_STORE, 32'h204, 32'h0, 32'h0, 32'h42, 32'h1234_5678, 2'd2, 1'b0);
        idle(2, 1'b1);

        stall_left = 2;
        for (int i = 0; i < 4; i++) send(K_ALU, 32'h600 + 32'(4 * i), 0, 32'h1000 + 32'(i), 0, 0, 2'd2, 1'b0);
        idle(4, 1'b1);

        cyc(1'b1, K_JAL, 32'h300, 32'h40, 0, 0, 0, 2'd2, 1'b0, 1'b1, 1'b1, f);
        idle(2, 1'b1);

        cyc(1'b1, K_ALU, 32'h700, 0, 32'hAAAA, 0, 0, 2'd2, 1'b0, 1'b0, 1'b0, f);
        cyc(1'b1, K_JAL, 32'h704, 32'h8, 0, 0, 0, 2'd2, 1'b0, 1'b0, 1'b0, f);
        io_in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(io_out_valid), 32'd0);
        chk("midrst_out_pc", io_out_pc, RPC);
        chk("midrst_redirect_valid", 32'(io_redirect_valid), 32'd0);
        chk("midrst_redirect_target", io_redirect_target, RPC);
        chk("midrst_out_wen", 32'(io_out_wen), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        send(K_JAL, 32'h500, 32'h10, 0, 0, 0, 2'd2, 1'b0);
        idle(2, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, imm, adder;
            pc    = $urandom;
            pc[1:0] = 2'b00;
            imm   = $urandom;
            if ($urandom_range(0, 1) == 0) imm[1:0] = 2'b00;
            adder = $urandom;
            if ($urandom_range(0, 1) == 0) adder[1:0] = 2'b00;
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)), pc, imm,
                $urandom, adder, $urandom, 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 3) != 0), f);
        end

        for (int t = 0; t < 20 && q.size() != 0; t++) idle(1, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);
        idle(1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
